// File: rtl/maze_chase_engine_if.sv
// Bus between the maze-chase game engine and its user: direction/start
// requests in, registered positions, lives, phase and tick out.
interface maze_chase_engine_if #(
    parameter int NUM_GHOSTS = 2
);
    logic                      btn_u;
    logic                      btn_d;
    logic                      btn_l;
    logic                      btn_r;
    logic                      btn_start;
    logic [9:0]                player_x;
    logic [8:0]                player_y;
    logic [10*NUM_GHOSTS-1:0]  ghost_x;
    logic [9*NUM_GHOSTS-1:0]   ghost_y;
    logic [2:0]                lives;
    logic [1:0]                phase;
    logic                      tick;

    modport master (
        output btn_u, btn_d, btn_l, btn_r, btn_start,
        input  player_x, player_y, ghost_x, ghost_y, lives, phase, tick
    );

    modport slave (
        input  btn_u, btn_d, btn_l, btn_r, btn_start,
        output player_x, player_y, ghost_x, ghost_y, lives, phase, tick
    );
endinterface

// File: rtl/maze_chase_engine.sv
// Maze-chase game state: movement tick, player and ghost positions,
// collision, lives and the IDLE/PLAY/DYING/OVER phase machine.
module maze_chase_engine #(
    parameter int          NUM_GHOSTS  = 2,
    parameter int          TICK_DIV    = 5000000,
    parameter int          STEP        = 10,
    parameter int          X_MIN       = 50,
    parameter int          X_MAX       = 390,
    parameter int          Y_MIN       = 50,
    parameter int          Y_MAX       = 390,
    parameter int          P_X0        = 50,
    parameter int          P_Y0        = 50,
    parameter int          G_X0        = 300,
    parameter int          G_Y0        = 300,
    parameter logic [15:0] G_MODE      = 16'h0000,
    parameter int          LIVES       = 3,
    parameter int          DEATH_TICKS = 8
) (
    input logic clk,
    input logic rst,
    maze_chase_engine_if.slave bus
);
    localparam int CW = $clog2(TICK_DIV);
    localparam int DW = (DEATH_TICKS > 1) ? $clog2(DEATH_TICKS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);
    localparam logic [DW-1:0] D_LAST = DW'(DEATH_TICKS - 1);
    localparam logic [10:0] S11 = 11'(STEP);
    localparam logic [10:0] XLO = 11'(X_MIN);
    localparam logic [10:0] XHI = 11'(X_MAX);
    localparam logic [10:0] YLO = 11'(Y_MIN);
    localparam logic [10:0] YHI = 11'(Y_MAX);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        DYING = 2'd2,
        OVER  = 2'd3
    } phase_t;

    phase_t          phase_q, phase_n;
    logic [CW-1:0]   cnt_q, cnt_n;
    logic            tick_q;
    logic [DW-1:0]   dcnt_q;
    logic [2:0]      lives_q;
    logic [9:0]      px_q, px_n;
    logic [8:0]      py_q, py_n;
    logic [9:0]      gx_q [NUM_GHOSTS];
    logic [9:0]      gx_n [NUM_GHOSTS];
    logic [8:0]      gy_q [NUM_GHOSTS];
    logic [8:0]      gy_n [NUM_GHOSTS];
    logic [10:0]     sx   [NUM_GHOSTS];
    logic [10:0]     sy   [NUM_GHOSTS];
    logic [NUM_GHOSTS-1:0] tog_q, use_x, use_y;
    logic [10:0]     px11, py11;
    logic            hit;
    logic            move_en, restore, reload, lose, d_clr, d_inc;

    // One step toward target on an axis, dropped if it would leave [lo,hi].
    function automatic logic [10:0] step_to(input logic [10:0] p,
                                            input logic [10:0] t,
                                            input logic [10:0] lo,
                                            input logic [10:0] hi);
        step_to = p;
        if (t > p) begin
            if (p + S11 <= hi) step_to = p + S11;
        end else if (t < p) begin
            if (p >= lo + S11) step_to = p - S11;
        end
    endfunction

    assign cnt_n = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_n;
            tick_q <= (cnt_n == CNT_LAST);
        end
    end

    assign px11 = {1'b0, px_q};
    assign py11 = {2'b00, py_q};

    always_comb begin
        px_n = px_q;
        py_n = py_q;
        if (bus.btn_u) begin
            if (py11 >= YLO + S11) py_n = py_q - 9'(STEP);
        end else if (bus.btn_d) begin
            if (py11 + S11 <= YHI) py_n = py_q + 9'(STEP);
        end else if (bus.btn_l) begin
            if (px11 >= XLO + S11) px_n = px_q - 10'(STEP);
        end else if (bus.btn_r) begin
            if (px11 + S11 <= XHI) px_n = px_q + 10'(STEP);
        end
    end

    always_comb begin
        hit   = 1'b0;
        use_x = '0;
        use_y = '0;
        for (int k = 0; k < NUM_GHOSTS; k++) begin
            gx_n[k] = gx_q[k];
            gy_n[k] = gy_q[k];
            if (gx_q[k] == px_q && gy_q[k] == py_q) hit = 1'b1;
            case (G_MODE[2*k +: 2])
                2'd0:    use_x[k] = ~tog_q[k];
                2'd1:    use_x[k] = (gx_q[k] != px_q);
                2'd2:    use_x[k] = (gy_q[k] == py_q);
                default: use_x[k] = 1'b0;
            endcase
            use_y[k] = (G_MODE[2*k +: 2] != 2'd3) && !use_x[k];
            sx[k] = step_to({1'b0, gx_q[k]}, px11, XLO, XHI);
            sy[k] = step_to({2'b00, gy_q[k]}, py11, YLO, YHI);
            if (use_x[k]) gx_n[k] = sx[k][9:0];
            if (use_y[k]) gy_n[k] = sy[k][8:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) phase_q <= IDLE;
        else     phase_q <= phase_n;
    end

    always_comb begin
        phase_n = phase_q;
        move_en = 1'b0;
        restore = 1'b0;
        reload  = 1'b0;
        lose    = 1'b0;
        d_clr   = 1'b0;
        d_inc   = 1'b0;
        unique case (phase_q)
            IDLE: begin
                if (bus.btn_start) phase_n = PLAY;
            end
            PLAY: begin
                if (tick_q) begin
                    if (hit) begin
                        lose    = 1'b1;
                        d_clr   = 1'b1;
                        phase_n = (lives_q <= 3'd1) ? OVER : DYING;
                    end else begin
                        move_en = 1'b1;
                    end
                end
            end
            DYING: begin
                if (tick_q) begin
                    if (dcnt_q == D_LAST) begin
                        restore = 1'b1;
                        phase_n = PLAY;
                    end else begin
                        d_inc = 1'b1;
                    end
                end
            end
            OVER: begin
                if (bus.btn_start) begin
                    restore = 1'b1;
                    reload  = 1'b1;
                    phase_n = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || reload)   lives_q <= 3'(LIVES);
        else if (lose)       lives_q <= lives_q - {2'b00, lives_q != 3'd0};
        if (rst || d_clr)    dcnt_q <= '0;
        else if (d_inc)      dcnt_q <= dcnt_q + 1'b1;
    end

    // Player and ghosts always read the pre-move positions of each other.
    always_ff @(posedge clk) begin
        if (rst || restore) begin
            px_q  <= 10'(P_X0);
            py_q  <= 9'(P_Y0);
            tog_q <= '0;
            for (int k = 0; k < NUM_GHOSTS; k++) begin
                gx_q[k] <= 10'(G_X0 + 20 * k);
                gy_q[k] <= 9'(G_Y0);
            end
        end else if (move_en) begin
            px_q  <= px_n;
            py_q  <= py_n;
            tog_q <= ~tog_q;
            for (int k = 0; k < NUM_GHOSTS; k++) begin
                gx_q[k] <= gx_n[k];
                gy_q[k] <= gy_n[k];
            end
        end
    end

    assign bus.player_x = px_q;
    assign bus.player_y = py_q;
    assign bus.lives    = lives_q;
    assign bus.phase    = phase_q;
    assign bus.tick     = tick_q;

    for (genvar g = 0; g < NUM_GHOSTS; g++) begin : g_out
        assign bus.ghost_x[10*g +: 10] = gx_q[g];
        assign bus.ghost_y[9*g +: 9]   = gy_q[g];
    end
endmodule

// File: tb/tb_maze_chase_engine.sv
// Random button/start/reset stimulus against a cycle-level game model
// built directly from the rules of the maze-chase game.
module tb_maze_chase_engine;
    localparam int          NG    = 4;
    localparam int          TDIV  = 4;
    localparam int          STEP  = 10;
    localparam int          XMIN  = 50;
    localparam int          XMAX  = 150;
    localparam int          YMIN  = 50;
    localparam int          YMAX  = 130;
    localparam int          PX0   = 50;
    localparam int          PY0   = 50;
    localparam int          GX0   = 80;
    localparam int          GY0   = 100;
    localparam logic [15:0] GMODE = 16'h00E4;
    localparam int          LIV   = 3;
    localparam int          DT    = 3;
    localparam int          CYCLES = 20000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    maze_chase_engine_if #(.NUM_GHOSTS(NG)) bus ();

    maze_chase_engine #(
        .NUM_GHOSTS(NG), .TICK_DIV(TDIV), .STEP(STEP),
        .X_MIN(XMIN), .X_MAX(XMAX), .Y_MIN(YMIN), .Y_MAX(YMAX),
        .P_X0(PX0), .P_Y0(PY0), .G_X0(GX0), .G_Y0(GY0),
        .G_MODE(GMODE), .LIVES(LIV), .DEATH_TICKS(DT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    int m_cnt, m_phase, m_lives, m_dying;
    int m_px, m_py;
    int m_gx[NG];
    int m_gy[NG];
    bit m_tog[NG];
    bit m_tick;

    function automatic int toward(input int p, input int t, input int lo, input int hi);
        if (t > p && p + STEP <= hi) return p + STEP;
        if (t < p && p - STEP >= lo) return p - STEP;
        return p;
    endfunction

    task automatic m_restore();
        m_px = PX0;
        m_py = PY0;
        for (int k = 0; k < NG; k++) begin
            m_gx[k] = GX0 + 20 * k;
            m_gy[k] = GY0;
            m_tog[k] = 1'b0;
        end
    endtask

    task automatic m_reset();
        m_cnt = 0;
        m_tick = 1'b0;
        m_phase = 0;
        m_lives = LIV;
        m_dying = 0;
        m_restore();
    endtask

    task automatic m_step(input bit r, input bit u, input bit d, input bit l,
                          input bit rt, input bit st);
        bit t;
        bit coll;
        int npx, npy, mode;
        if (r) begin
            m_reset();
            return;
        end
        t = (m_cnt == TDIV - 1);
        m_cnt = t ? 0 : m_cnt + 1;
        m_tick = (m_cnt == TDIV - 1);
        case (m_phase)
            0: if (st) m_phase = 1;
            1: if (t) begin
                coll = 1'b0;
                for (int k = 0; k < NG; k++)
                    if (m_gx[k] == m_px && m_gy[k] == m_py) coll = 1'b1;
                if (coll) begin
                    if (m_lives > 0) m_lives--;
                    m_dying = 0;
                    m_phase = (m_lives == 0) ? 3 : 2;
                end else begin
                    npx = m_px;
                    npy = m_py;
                    if (u)       begin if (m_py - STEP >= YMIN) npy = m_py - STEP; end
                    else if (d)  begin if (m_py + STEP <= YMAX) npy = m_py + STEP; end
                    else if (l)  begin if (m_px - STEP >= XMIN) npx = m_px - STEP; end
                    else if (rt) begin if (m_px + STEP <= XMAX) npx = m_px + STEP; end
                    for (int k = 0; k < NG; k++) begin
                        mode = int'((GMODE >> (2 * k)) & 16'h3);
                        if ((mode == 0 && !m_tog[k]) ||
                            (mode == 1 && m_gx[k] != m_px) ||
                            (mode == 2 && m_gy[k] == m_py))
                            m_gx[k] = toward(m_gx[k], m_px, XMIN, XMAX);
                        else if (mode != 3)
                            m_gy[k] = toward(m_gy[k], m_py, YMIN, YMAX);
                        m_tog[k] = !m_tog[k];
                    end
                    m_px = npx;
                    m_py = npy;
                end
            end
            2: if (t) begin
                m_dying++;
                if (m_dying == DT) begin
                    m_restore();
                    m_phase = 1;
                end
            end
            default: if (st) begin
                m_lives = LIV;
                m_restore();
                m_phase = 0;
            end
        endcase
    endtask

    task automatic compare_all();
        check("phase", int'(bus.phase), m_phase);
        check("lives", int'(bus.lives), m_lives);
        check("tick", int'(bus.tick), int'(m_tick));
        check("player_x", int'(bus.player_x), m_px);
        check("player_y", int'(bus.player_y), m_py);
        for (int k = 0; k < NG; k++) begin
            check($sformatf("ghost_x%0d", k), int'(bus.ghost_x[10*k +: 10]), m_gx[k]);
            check($sformatf("ghost_y%0d", k), int'(bus.ghost_y[9*k +: 9]), m_gy[k]);
        end
    endtask

    initial begin
        bit r;
        bus.btn_u = 1'b0;
        bus.btn_d = 1'b0;
        bus.btn_l = 1'b0;
        bus.btn_r = 1'b0;
        bus.btn_start = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        m_reset();
        #1;
        compare_all();
        for (int c = 0; c < CYCLES && errors < 20; c++) begin
            @(negedge clk);
            r = ($urandom_range(0, 299) == 0);
            rst = r;
            bus.btn_u = ($urandom_range(0, 3) == 0);
            bus.btn_d = ($urandom_range(0, 3) == 0);
            bus.btn_l = ($urandom_range(0, 3) == 0);
            bus.btn_r = ($urandom_range(0, 3) == 0);
            bus.btn_start = ($urandom_range(0, 15) == 0);
            @(posedge clk);
            m_step(r, bus.btn_u, bus.btn_d, bus.btn_l, bus.btn_r, bus.btn_start);
            #1;
            compare_all();
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
